// File: rtl/sm_addsub_unit.sv
// Signed-magnitude add/subtract unit with a one-hot eight-state sequencer.
// Operands are latched on leaving T0. The magnitude path is WIDTH bits wide,
// with the end carry held in E. The result, sign and overflow flag are
// registered in T7, and a one-cycle done strobe follows on return to T0.
module sm_addsub_unit #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             qa,
    input  logic             qs,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             r_sign,
    output logic [WIDTH-1:0] r_mag,
    output logic             avf,
    output logic             busy,
    output logic             done,
    output logic [7:0]       state
);

    typedef enum logic [7:0] {
        T0 = 8'b0000_0001,
        T1 = 8'b0000_0010,
        T2 = 8'b0000_0100,
        T3 = 8'b0000_1000,
        T4 = 8'b0001_0000,
        T5 = 8'b0010_0000,
        T6 = 8'b0100_0000,
        T7 = 8'b1000_0000
    } state_t;

    state_t           cur;
    logic             as_q;
    logic             bs_q;
    logic             e_q;
    logic             avf_int;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] fin_mag;

    // Datapath: magnitude sum, magnitude difference (A + ~B + 1) and the final magnitude.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        sum_add = {1'b0, a_q} + {1'b0, b_q};
        sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        fin_mag = (avf_int && SAT) ? {WIDTH{1'b1}} : a_q;
    end

    // Sequencer, operand registers and output registers. Reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: all state updates use <= so every register samples pre-edge values.
            cur     <= T0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= 1'b0;
            avf_int <= 1'b0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            avf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur)
                T0: begin
                    if (qs || qa) begin
                        as_q    <= a_sign;
                        a_q     <= a_mag;
                        bs_q    <= b_sign;
                        b_q     <= b_mag;
                        e_q     <= 1'b0;
                        avf_int <= 1'b0;
                        // Subtract takes priority and detours through T1 to flip Bs.
                        cur     <= qs ? T1 : T2;
                    end
                end
                T1: begin
                    bs_q <= ~bs_q;
                    cur  <= T2;
                end
                T2: begin
                    cur <= (as_q == bs_q) ? T3 : T4;
                end
                T3: begin
                    {e_q, a_q} <= sum_add;
                    avf_int    <= sum_add[WIDTH];
                    cur        <= T7;
                end
                T4: begin
                    {e_q, a_q} <= sum_sub;
                    avf_int    <= 1'b0;
                    cur        <= T5;
                end
                T5: begin
                    // E set means A >= B, so the difference is already in magnitude form.
                    cur <= e_q ? T7 : T6;
                end
                T6: begin
                    a_q  <= ~a_q + WIDTH'(1);
                    as_q <= ~as_q;
                    cur  <= T7;
                end
                T7: begin
                    r_mag  <= fin_mag;
                    // A zero magnitude is always reported as positive zero.
                    r_sign <= (fin_mag == '0) ? 1'b0 : as_q;
                    avf    <= avf_int;
                    done   <= 1'b1;
                    cur    <= T0;
                end
                default: cur <= T0;
            endcase
        end
    end

    assign state = cur;
    assign busy  = ~cur[0];

endmodule

// File: tb/tb_sm_addsub_unit.sv
// Bench for sm_addsub_unit. It runs a wrap instance and a saturate instance
// in lockstep on the same inputs. Each result is checked against an
// integer-arithmetic model and against hand-computed literals.
module tb_sm_addsub_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         qa, qs, a_sign, b_sign;
    logic [W-1:0] a_mag, b_mag;

    logic         r_sign, avf, busy, done;
    logic [W-1:0] r_mag;
    logic [7:0]   state;
    logic         s_sign, s_avf, s_busy, s_done;
    logic [W-1:0] s_mag;
    logic [7:0]   s_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Expected held outputs of the last completed operation, per instance.
    logic         cur_sign = 1'b0, cur_avf = 1'b0, cur_s_sign = 1'b0, cur_s_avf = 1'b0;
    logic [W-1:0] cur_mag = '0, cur_s_mag = '0;

    sm_addsub_unit #(.WIDTH(W), .SAT(1'b0)) dut (
        .clk(clk), .reset(reset), .qa(qa), .qs(qs),
        .a_sign(a_sign), .b_sign(b_sign), .a_mag(a_mag), .b_mag(b_mag),
        .r_sign(r_sign), .r_mag(r_mag), .avf(avf), .busy(busy), .done(done), .state(state)
    );

    sm_addsub_unit #(.WIDTH(W), .SAT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .qa(qa), .qs(qs),
        .a_sign(a_sign), .b_sign(b_sign), .a_mag(a_mag), .b_mag(b_mag),
        .r_sign(s_sign), .r_mag(s_mag), .avf(s_avf), .busy(s_busy), .done(s_done), .state(s_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Signed-integer view of the operation: result value, overflow and latency.
    function automatic void model(input logic sub, input logic as, input int am,
                                  input logic bs, input int bm, input bit sat,
                                  output logic rs, output int rm, output logic ra,
                                  output int lat);
        logic ebs;
        int   va, vb, res, mag;
        ebs = bs ^ sub;
        va  = as  ? -am : am;
        vb  = ebs ? -bm : bm;
        res = va + vb;
        mag = (res < 0) ? -res : res;
        ra  = (as == ebs) && (mag > (2**W - 1));
        if (ra) rm = sat ? (2**W - 1) : (mag % (2**W));
        else    rm = mag;
        rs  = (rm == 0) ? 1'b0 : (res < 0);
        lat = 4 + int'(sub) + ((as != ebs) ? ((am < bm) ? 2 : 1) : 0);
    endfunction

    // Per-cycle checks: one-hot state, busy, held outputs, lockstep instances.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            check("onehot", $onehot(state), 1);
            check("busy", busy, state != 8'h01);
            check("r_sign_hold", r_sign, cur_sign);
            check("r_mag_hold", r_mag, cur_mag);
            check("avf_hold", avf, cur_avf);
            check("s_sign_hold", s_sign, cur_s_sign);
            check("s_mag_hold", s_mag, cur_s_mag);
            check("s_avf_hold", s_avf, cur_s_avf);
            check("s_state_lockstep", s_state, state);
        end
    end

    task automatic run_op(input string name, input logic sub, input logic both, input logic pulse,
                          input logic as, input int am, input logic bs, input int bm,
                          input logic es, input int em, input logic eavf, input int elat,
                          input logic [63:0] path);
        logic       ms, ma, mss, msa;
        int         mm, ml, msm, msl, n, d0;
        logic [7:0] seq [1:8];
        model(sub, as, am, bs, bm, 1'b0, ms, mm, ma, ml);
        model(sub, as, am, bs, bm, 1'b1, mss, msm, msa, msl);
        check({name, ":model_sign"}, ms, es);
        check({name, ":model_mag"}, mm, em);
        check({name, ":model_avf"}, ma, eavf);
        check({name, ":model_lat"}, ml, elat);

        @(negedge clk);
        a_sign = as; a_mag = am[W-1:0]; b_sign = bs; b_mag = bm[W-1:0];
        qs = sub; qa = !sub || both;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        qa = 1'b0; qs = 1'b0;
        // Scramble the inputs so that only the latched operands can give the right answer.
        a_mag = ~a_mag; b_mag = ~b_mag; a_sign = ~a_sign; b_sign = ~b_sign;
        n = 1;
        while (!done && n <= 20) begin
            if (n <= 8) seq[n] = state;
            if (pulse) qa = (n == 2);
            @(posedge clk);
            #1;
            n++;
        end
        qa = 1'b0;
        if (n <= 8) seq[n] = state;
        if (!done) begin
            check({name, ":done_timeout"}, 0, 1);
        end else begin
            cur_sign = ms; cur_mag = mm[W-1:0]; cur_avf = ma;
            cur_s_sign = mss; cur_s_mag = msm[W-1:0]; cur_s_avf = msa;
        end
        check({name, ":latency"}, n, elat);
        check({name, ":r_sign"}, r_sign, es);
        check({name, ":r_mag"}, r_mag, em);
        check({name, ":avf"}, avf, eavf);
        check({name, ":s_sign"}, s_sign, mss);
        check({name, ":s_mag"}, s_mag, msm);
        check({name, ":s_avf"}, s_avf, msa);
        if (path != 64'd0) begin
            for (int i = 1; i <= elat && i <= 8; i++)
                check({name, ":path"}, seq[i], path[8*(i-1) +: 8]);
        end
        repeat (2) @(negedge clk);
        check({name, ":one_done"}, done_cnt, d0 + 1);
        check({name, ":idle"}, state, 8'h01);
    endtask

    initial begin
        int d0;
        reset = 1'b1; qa = 1'b0; qs = 1'b0;
        a_sign = 1'b0; b_sign = 1'b0; a_mag = '0; b_mag = '0;
        #1;
        check("rst_state", state, 8'h01);
        check("rst_r_mag", r_mag, 0);
        check("rst_r_sign", r_sign, 0);
        check("rst_avf", avf, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        //     name            sub  both pulse as  am   bs  bm   es   em   avf  lat path
        run_op("add_5_3",      0, 0, 0, 0, 5,   0, 3,   0, 8,   0, 4, 64'h0000_0000_0180_0804);
        run_op("add_200_100",  0, 0, 0, 0, 200, 0, 100, 0, 44,  1, 4, 64'd0);
        check("sat_200_100_mag", s_mag, 255);
        check("sat_200_100_avf", s_avf, 1);
        run_op("add_3_m5",     0, 0, 0, 0, 3,   1, 5,   1, 2,   0, 6, 64'h0000_0180_4020_1004);
        run_op("sub_m7_m7",    1, 0, 0, 1, 7,   1, 7,   0, 0,   0, 6, 64'h0000_0180_2010_0402);
        run_op("add_m0_m0",    0, 0, 0, 1, 0,   1, 0,   0, 0,   0, 4, 64'd0);
        run_op("both_9_4",     1, 1, 1, 0, 9,   0, 4,   0, 5,   0, 6, 64'h0000_0180_2010_0402);
        run_op("sub_10_20",    1, 0, 0, 0, 10,  0, 20,  1, 10,  0, 7, 64'd0);
        run_op("add_m128_m128",0, 0, 0, 1, 128, 1, 128, 0, 0,   1, 4, 64'd0);
        check("sat_m128_sign", s_sign, 1);
        check("sat_m128_mag", s_mag, 255);
        run_op("add_255_m255", 0, 0, 0, 0, 255, 1, 255, 0, 0,   0, 5, 64'd0);
        run_op("sub_m255_1",   1, 0, 0, 1, 255, 0, 1,   0, 0,   1, 5, 64'd0);
        run_op("add_m100_m27", 0, 0, 0, 1, 100, 1, 27,  1, 127, 0, 4, 64'd0);

        // Abort an operation in T4 and confirm that everything clears with no done.
        @(negedge clk);
        a_sign = 1'b0; a_mag = 8'd3; b_sign = 1'b1; b_mag = 8'd5; qa = 1'b1;
        @(posedge clk);
        #1;
        qa = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_state", state, 8'h10);
        reset = 1'b1;
        cur_sign = 1'b0; cur_mag = '0; cur_avf = 1'b0;
        cur_s_sign = 1'b0; cur_s_mag = '0; cur_s_avf = 1'b0;
        #1;
        check("abort_state", state, 8'h01);
        check("abort_r_mag", r_mag, 0);
        check("abort_r_sign", r_sign, 0);
        check("abort_avf", avf, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_s_mag", s_mag, 0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt, d0);

        run_op("add_1_1",      0, 0, 0, 0, 1,   0, 1,   0, 2,   0, 4, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
